// File: rtl/id_ex_skid_stage_if.sv
// ID->EX handshake bundle: upstream valid/ready beat plus downstream valid/ready beat.
// master = id/ex side driver view, slave = the skid stage itself.
interface id_ex_skid_stage_if #(
  parameter int unsigned PAYLOAD_W  = 128,
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [PAYLOAD_W-1:0]  in_data;
  logic [REG_ADDR_W-1:0] in_wd;
  logic                  in_wreg;

  logic                  out_valid;
  logic                  out_ready;
  logic [PAYLOAD_W-1:0]  out_data;
  logic [REG_ADDR_W-1:0] out_wd;
  logic                  out_wreg;

  modport master (
    output in_valid, in_data, in_wd, in_wreg, out_ready,
    input  in_ready, out_valid, out_data, out_wd, out_wreg
  );

  modport slave (
    input  in_valid, in_data, in_wd, in_wreg, out_ready,
    output in_ready, out_valid, out_data, out_wd, out_wreg
  );
endinterface

// File: rtl/id_ex_skid_stage.sv
// ID->EX pipeline register with a 2-entry skid buffer, single-cycle flush and NOP bubbles.
// Optional stall/bubble performance counters are enabled with `define ID_EX_PERF_CNT_EN.
module id_ex_skid_stage #(
  parameter int unsigned PAYLOAD_W  = 128,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_rdy,
  input  logic                  i_flush,
  id_ex_skid_stage_if.slave     bus,
  output logic [1:0]            o_occupancy
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]           o_stall_cnt,
  output logic [31:0]           o_bubble_cnt
`endif
);

  // Main entry M drives the outputs; skid entry S only fills when M stalls.
  logic                  r_m_valid;
  logic [PAYLOAD_W-1:0]  r_m_data;
  logic [REG_ADDR_W-1:0] r_m_wd;
  logic                  r_m_wreg;
  logic                  r_s_valid;
  logic [PAYLOAD_W-1:0]  r_s_data;
  logic [REG_ADDR_W-1:0] r_s_wd;
  logic                  r_s_wreg;
  logic                  r_in_ready;

  logic                  w_m_valid;
  logic [PAYLOAD_W-1:0]  w_m_data;
  logic [REG_ADDR_W-1:0] w_m_wd;
  logic                  w_m_wreg;
  logic                  w_s_valid;
  logic [PAYLOAD_W-1:0]  w_s_data;
  logic [REG_ADDR_W-1:0] w_s_wd;
  logic                  w_s_wreg;

  logic                  w_accept;
  logic                  w_consume;

  assign w_accept  = bus.in_valid & r_in_ready;
  assign w_consume = r_m_valid & bus.out_ready;

  always_comb begin
    w_m_valid = r_m_valid;
    w_m_data  = r_m_data;
    w_m_wd    = r_m_wd;
    w_m_wreg  = r_m_wreg;
    w_s_valid = r_s_valid;
    w_s_data  = r_s_data;
    w_s_wd    = r_s_wd;
    w_s_wreg  = r_s_wreg;

    if (i_flush) begin
      w_m_valid = 1'b0;
      w_m_data  = '0;
      w_m_wd    = '0;
      w_m_wreg  = 1'b0;
      w_s_valid = 1'b0;
      w_s_data  = '0;
      w_s_wd    = '0;
      w_s_wreg  = 1'b0;
    end else begin
      unique case ({r_m_valid, r_s_valid})
        2'b00: begin
          if (w_accept) begin
            w_m_valid = 1'b1;
            w_m_data  = bus.in_data;
            w_m_wd    = bus.in_wd;
            w_m_wreg  = bus.in_wreg;
          end
        end
        2'b10: begin
          if (w_consume && w_accept) begin
            w_m_data = bus.in_data;
            w_m_wd   = bus.in_wd;
            w_m_wreg = bus.in_wreg;
          end else if (w_consume) begin
            w_m_valid = 1'b0;
          end else if (w_accept) begin
            w_s_valid = 1'b1;
            w_s_data  = bus.in_data;
            w_s_wd    = bus.in_wd;
            w_s_wreg  = bus.in_wreg;
          end
        end
        2'b11: begin
          if (w_consume) begin
            w_m_data  = r_s_data;
            w_m_wd    = r_s_wd;
            w_m_wreg  = r_s_wreg;
            w_s_valid = 1'b0;
          end
        end
        default: begin
          // S without M cannot arise; drop back to empty if it ever does.
          w_m_valid = 1'b0;
          w_s_valid = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_valid  <= 1'b0;
      r_m_data   <= '0;
      r_m_wd     <= '0;
      r_m_wreg   <= 1'b0;
      r_s_valid  <= 1'b0;
      r_s_data   <= '0;
      r_s_wd     <= '0;
      r_s_wreg   <= 1'b0;
      r_in_ready <= 1'b1;
    end else if (i_rdy) begin
      r_m_valid  <= w_m_valid;
      r_m_data   <= w_m_data;
      r_m_wd     <= w_m_wd;
      r_m_wreg   <= w_m_wreg;
      r_s_valid  <= w_s_valid;
      r_s_data   <= w_s_data;
      r_s_wd     <= w_s_wd;
      r_s_wreg   <= w_s_wreg;
      r_in_ready <= ~w_s_valid;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_m_valid;
  assign bus.out_data  = r_m_valid ? r_m_data : '0;
  assign bus.out_wd    = r_m_valid ? r_m_wd : '0;
  assign bus.out_wreg  = r_m_valid & r_m_wreg;
  assign o_occupancy   = {r_m_valid & r_s_valid, r_m_valid ^ r_s_valid};

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else if (i_rdy) begin
      if (r_m_valid && !bus.out_ready) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (!r_m_valid) r_bubble_cnt <= r_bubble_cnt + 32'd1;
    end
  end

  assign o_stall_cnt  = r_stall_cnt;
  assign o_bubble_cnt = r_bubble_cnt;
`endif

endmodule
